wb_prefetch_fifo: RTL
=====================

WB_PREFETCH_FIFO -- requirements
Module: wb_prefetch_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, FIFO entries (power of two, >=2); RESET_PC, 24'h000000, first fetch address after reset.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_flush  in  1  redirect fetch stream (branch/jump).
REQ-005 i_flush_addr  in  24  new fetch word address, sampled when i_flush=1.
REQ-006 o_valid  out  1  head entry valid.
REQ-007 o_instr  out  16  head instruction word.
REQ-008 o_instr_addr  out  24  word address of head entry.
REQ-009 i_ready  in  1  consumer pops head when o_valid & i_ready.
REQ-010 o_mem_addr  out  24  word address to bus adapter.
REQ-011 o_mem_data  out  16  constant 16'h0000 (read-only master).
REQ-012 o_mem_req  out  1  request to bus adapter.
REQ-013 o_mem_we  out  1  constant 0.
REQ-014 o_mem_next  out  1  continue burst after current ack.
REQ-015 i_mem_ack  in  1  read data valid / transfer done.
REQ-016 i_mem_data  in  16  read data, valid with i_mem_ack.

Function
REQ-017 Block SHALL keep fetch pointer pc, FIFO (data only) with count 0..DEPTH, head address register, state in {IDLE, FETCH, FLUSH_WAIT}.
REQ-018 o_mem_req SHALL be 1 in FETCH and FLUSH_WAIT, 0 in IDLE; at most one transfer outstanding.
REQ-019 o_mem_next SHALL be 1 only in FETCH, i_flush=0, and (count + 1 - pop) < DEPTH; pop = o_valid & i_ready.
REQ-020 o_mem_addr SHALL be pc+1 (24-bit wrap) when i_mem_ack & o_mem_next, else pc; adapter latches address on the ack cycle.
REQ-021 IDLE: no flush and (count - pop) < DEPTH -> FETCH next cycle; else stay.
REQ-022 FETCH, ack, no flush: push i_mem_data, pc <= pc+1; o_mem_next=1 -> stay FETCH, else -> IDLE.
REQ-023 FETCH, flush, no ack: -> FLUSH_WAIT; pc <= i_flush_addr.
REQ-024 FETCH, flush and ack same cycle: ack data discarded, o_mem_next=0, pc <= i_flush_addr, -> IDLE.
REQ-025 FLUSH_WAIT: o_mem_next=0; ack data discarded; ack -> IDLE; further flush updates pc only.
REQ-026 Flush SHALL clear FIFO (count <= 0) and set head address <= i_flush_addr, in any state; flush beats pop and push in same cycle.
REQ-027 Pop SHALL advance head pointer, head address +1 (24-bit wrap); push and pop same cycle leave count unchanged.
REQ-028 Push SHALL never occur with count=DEPTH and no pop; REQ-019/021 guarantee this.
REQ-029 o_valid = (count != 0); o_instr/o_instr_addr undefined-but-stable when o_valid=0; o_valid may fall no earlier than the cycle after flush.
REQ-030 Latency: flush at cycle N -> o_mem_req with new address no earlier than N+2 when idle bus; acked word visible on o_valid the cycle after ack.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 During i_rst: state IDLE, count 0, pointers 0, pc and head address RESET_PC, o_mem_req 0, o_mem_next 0, o_valid 0.
REQ-033 Reset mid-transfer SHALL abandon outstanding transfer; late ack after reset ignored while in IDLE.
REQ-034 First request after reset SHALL be at RESET_PC in cycle after reset deasserts +1.

Verification
REQ-035 Reset release, ack every cycle, i_ready=0 -> words at 0,1,2,3 pushed, o_mem_next=0 on 4th ack, o_mem_req falls, count=4.
REQ-036 Full FIFO, i_ready=1 one cycle -> count 3, new request at address 4, o_instr_addr of head = 1.
REQ-037 Flush to 24'h001000 while FETCH waiting for ack -> FLUSH_WAIT, ack data dropped, o_valid=0, next request address 24'h001000.
REQ-038 Flush and ack same cycle -> data not pushed, o_mem_next=0, next burst starts at flush address.
REQ-039 pc=24'hFFFFFF fetch with continuous acks -> next address 24'h000000, o_instr_addr wraps identically.
REQ-040 Random ack latency/ready/flush, scoreboard -> every popped o_instr equals memory model at o_instr_addr, no overflow, no data after flush from old stream.

Source files
------------

// File: rtl/wb_prefetch_fifo_if.sv
// Bundled consumer, redirect and memory-adapter signals of the instruction prefetcher.
// The master modport is the prefetcher's view; slave is the surrounding core/adapter side.
interface wb_prefetch_fifo_if;
    logic        i_flush;
    logic [23:0] i_flush_addr;
    logic        o_valid;
    logic [15:0] o_instr;
    logic [23:0] o_instr_addr;
    logic        i_ready;
    logic [23:0] o_mem_addr;
    logic [15:0] o_mem_data;
    logic        o_mem_req;
    logic        o_mem_we;
    logic        o_mem_next;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;

    modport master (
        input  i_flush,
        input  i_flush_addr,
        output o_valid,
        output o_instr,
        output o_instr_addr,
        input  i_ready,
        output o_mem_addr,
        output o_mem_data,
        output o_mem_req,
        output o_mem_we,
        output o_mem_next,
        input  i_mem_ack,
        input  i_mem_data
    );

    modport slave (
        output i_flush,
        output i_flush_addr,
        input  o_valid,
        input  o_instr,
        input  o_instr_addr,
        output i_ready,
        input  o_mem_addr,
        input  o_mem_data,
        input  o_mem_req,
        input  o_mem_we,
        input  o_mem_next,
        output i_mem_ack,
        output i_mem_data
    );
endinterface

// File: rtl/wb_prefetch_fifo.sv
// Instruction prefetcher: bursts 16-bit words from a read-only bus adapter into a small FIFO
// and presents them with their word address; a flush redirects the stream and drops old data.
module wb_prefetch_fifo #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [23:0] RESET_PC = 24'h000000
) (
    input logic                 i_clk,
    input logic                 i_rst,
    wb_prefetch_fifo_if.master  bus_io
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StFlushWait} state_e;

    state_e        state_q, state_d;
    logic [23:0]   pc_q, pc_d;
    logic [23:0]   head_addr_q, head_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   mem_q [DEPTH];

    logic          flush, ack, pop, push;
    logic          mem_req, mem_next;
    logic [23:0]   mem_addr;
    logic [CW:0]   occ_after_push, occ_after_pop;

    assign flush = bus_io.i_flush;
    assign ack   = bus_io.i_mem_ack;
    assign pop   = (count_q != '0) & bus_io.i_ready;
    // Data acked while flushing (or in any non-fetch state) belongs to the old stream.
    assign push  = (state_q == StFetch) & ack & ~flush;

    // Occupancy the FIFO would reach if one more word landed this cycle, and after the pop.
    assign occ_after_push = {1'b0, count_q} + (CW + 1)'(1) - (CW + 1)'(pop);
    assign occ_after_pop  = {1'b0, count_q} - (CW + 1)'(pop);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!flush && (occ_after_pop < DepthW)) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (flush) begin
                    state_d = ack ? StIdle : StFlushWait;
                end else if (ack) begin
                    state_d = mem_next ? StFetch : StIdle;
                end
            end
            StFlushWait: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        mem_req  = (state_q != StIdle);
        mem_next = (state_q == StFetch) & ~flush & (occ_after_push < DepthW);
        // The adapter latches the follow-on address in the ack cycle of a continued burst.
        mem_addr = (ack & mem_next) ? pc_q + 24'd1 : pc_q;
    end

    assign bus_io.o_mem_req    = mem_req;
    assign bus_io.o_mem_next   = mem_next;
    assign bus_io.o_mem_addr   = mem_addr;
    assign bus_io.o_mem_data   = 16'h0000;
    assign bus_io.o_mem_we     = 1'b0;
    assign bus_io.o_valid      = (count_q != '0);
    assign bus_io.o_instr      = mem_q[rd_ptr_q];
    assign bus_io.o_instr_addr = head_addr_q;

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        pc_d        = pc_q;
        head_addr_d = head_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (flush) begin
            // Flush wins over a simultaneous push or pop.
            pc_d        = bus_io.i_flush_addr;
            head_addr_d = bus_io.i_flush_addr;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 24'd1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                head_addr_d = head_addr_q + 24'd1;
                rd_ptr_d    = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q        <= RESET_PC;
            head_addr_q <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            head_addr_q <= head_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem_q[wr_ptr_q] <= bus_io.i_mem_data;
        end
    end

endmodule
